display_digit_driver: RTL and testbench
=======================================

# display_digit_driver

Consumer end of the display scan interface. It takes the 2-bit digit select `SEL` produced by `display_controller` and drives the physical 4-digit 7-segment display: active-low anodes, active-low segments, and a decimal point. Timer logic loads a 4-digit BCD value through a valid/ready handshake. The value is double-buffered and committed only at a scan-frame boundary, so a frame never mixes old and new digits. Optional per-digit blinking is driven by an internal divider.

## Interface
- `BLINK_DIV`, default 50_000_000: `CLK` cycles per blink half-period; must be ≥ 2.
- `CLK`  in  1  system clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `SEL`  in  2  current digit index from `display_controller`; 0 = rightmost digit.
- `DATA_IN`  in  16  BCD digits; `[3:0]` = digit 0, up to `[15:12]` = digit 3.
- `DATA_VALID`  in  1  `DATA_IN` is offered this cycle.
- `DATA_READY`  out  1  the pending buffer is empty, so an offer is accepted.
- `BLINK_MASK`  in  4  per-digit blink enable, sampled every cycle.
- `COLON`  in  1  light the decimal point on digit 2.
- `AN`  out  4  anodes, active-low, one-hot-low.
- `SEG`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `DP`  out  1  decimal point, active-low.

## Operation
- **Handshake.** A transfer occurs when `DATA_VALID && DATA_READY` on a rising edge. `DATA_IN` is then captured into the pending buffer and `DATA_READY` goes low on the next cycle. Offers made while `DATA_READY` is low are ignored; the producer must hold them.
- **Frame boundary.** A boundary is the cycle in which registered `sel_q == 3` and `SEL == 0`. At a boundary with the pending buffer full, the pending value is copied to the active buffer and the pending buffer is emptied. `DATA_READY` returns high on the following cycle.
- **Simultaneous events.** A commit uses the pending state from before the current cycle's acceptance. If a transfer and a boundary fall in the same cycle while the buffer is empty, the transfer is accepted and waits for the next boundary.
- **Out-of-order `SEL`.** Any `SEL` sequence is legal. Only the 3→0 transition counts as a boundary.
- **Decode.** Each active nibble maps as follows:
  - 0–9: standard 7-segment glyph.
  - A–F: a dash (segment g only, `SEG = 7'b0111111`).
- **Blink.** A counter runs 0..`BLINK_DIV`-1 and toggles `blink_on` when it wraps. While `blink_on` is 0, every digit with its `BLINK_MASK` bit set is blanked (`SEG = 7'h7F`, `DP = 1`). Its anode still scans.
- **Decimal point.** `DP = 0` only when the displayed digit is 2, `COLON` is 1, and the digit is not blanked.
- **State.** The pending buffer has two states, EMPTY and FULL:
  - EMPTY→FULL on a transfer.
  - FULL→EMPTY on a boundary.
  - Otherwise the state holds.

## Timing
- All outputs are registered, with 1-cycle latency from `SEL` to `AN`/`SEG`/`DP`. The outputs show digit `SEL(t)` at t+1.
- A new value is visible starting with the digit-0 output of the frame after commit. Commit occurs at the boundary cycle, and the output appears one cycle later.
- Reset values (asserted asynchronously; release is synchronous to `CLK`):
  - outputs: `AN = 4'b1111`, `SEG = 7'h7F`, `DP = 1`, `DATA_READY = 1`;
  - internal: active buffer = 16'h0000, pending = EMPTY, `sel_q = 0`, blink counter = 0, `blink_on = 1`.
- Reset mid-transfer discards the pending value. The first post-reset frame shows 0000.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - **Defined:** digits 3, 2, 1 are blanked when they and every higher digit are 0. Digit 0 is never blanked. Nibbles A–F count as non-zero. `DP` is unaffected by this blanking.
  - **Undefined:** all four digits are always shown.

## Structure
- Package `display_pkg`:
  - `bcd_t` (logic [3:0]);
  - segment glyph constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`;
  - `NUM_DIGITS = 4`;
  - `sel_t` (logic [1:0]), shared with `display_controller`.
- Sub-module `seg7_decoder`: purely combinational, `bcd_t` → 7-bit active-low glyph using the package constants. All state (buffers, handshake, blink, output registers) stays in `display_digit_driver`.

## Test plan
- **Reset.** Hold `RST_N = 0` for 10 cycles → `AN = 1111`, `SEG = 7F`, `DP = 1`, `DATA_READY = 1`. Then cycle `SEL` 0..3 → digits show "0" (`SEG = 7'b1000000`) with `AN` = 1110, 1101, 1011, 0111, each one cycle after `SEL`.
- **Handshake and commit.** Offer 16'h1234 at `SEL = 1` → `DATA_READY` is 0 next cycle. The remaining frame still shows 0000. After the 3→0 boundary, `DATA_READY` returns to 1 and the next frame shows 4, 3, 2, 1 on digits 0–3.
- **Back-pressure and same-cycle boundary.** Offer 16'h5678 while FULL → ignored. Offer it exactly on the boundary cycle with pending EMPTY → accepted, displayed only after the following boundary.
- **Invalid BCD.** Load 16'h00A9 → digit 1 shows the dash `7'b0111111` and digit 0 shows "9".
- **Blink and colon.** Use `BLINK_DIV = 4`, `BLINK_MASK = 0001`, `COLON = 1` → digit 0 is blanked for 4 of every 8 cycles. `DP = 0` on digit 2 except when digit 2's mask bit is set and `blink_on = 0`.
- **Leading-zero blanking.** With `LEADING_ZERO_BLANK_EN`, load 16'h0050 → digits 3 and 2 are blank, digits 1 and 0 show "5" and "0". With 16'h0000 only digit 0 shows "0". Without the macro, all four digits are shown.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the display scan path.
//   bcd_t      - one BCD digit
//   sel_t      - digit index driven by display_controller (0 = rightmost)
//   SEG_*      - active-low glyphs, bit order {g,f,e,d,c,b,a}
//   NUM_DIGITS - number of physical digits
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;
    typedef logic [1:0] sel_t;

    typedef enum logic {
        PendEmpty,
        PendFull
    } pend_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational BCD to active-low 7-segment glyph.
//   i_bcd - digit value; 0-9 give the numeral, A-F give a dash
//   o_seg - segments {g,f,e,d,c,b,a}, active-low
module seg7_decoder
    import display_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_digit_driver.sv
// display_digit_driver: drives a 4-digit 7-segment display from the scan index SEL.
// A 16-bit BCD value is accepted over DATA_VALID/DATA_READY into a pending buffer
// and committed to the active buffer only at a 3->0 SEL transition, so a frame never
// mixes old and new digits. Per-digit blinking uses an internal BLINK_DIV divider.
// Ports:
//   CLK, RST_N            - clock, asynchronous active-low reset
//   SEL                   - digit index being scanned (0 = rightmost)
//   DATA_IN/VALID/READY   - value load handshake (READY = pending buffer empty)
//   BLINK_MASK            - per-digit blink enable
//   COLON                 - light the decimal point on digit 2
//   AN, SEG, DP           - registered active-low anode/segment/decimal point outputs
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module display_digit_driver
    import display_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 50_000_000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  sel_t                  SEL,
    input  logic [15:0]           DATA_IN,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic [NUM_DIGITS-1:0] BLINK_MASK,
    input  logic                  COLON,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [6:0]            SEG,
    output logic                  DP
);

    localparam int unsigned     CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    pend_state_e           r_pend_state, w_pend_state_d;
    logic [15:0]           r_pending;
    logic [15:0]           r_active, w_active_d;
    sel_t                  r_sel_q;
    logic [CNT_W-1:0]      r_blink_cnt;
    logic                  r_blink_on;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    logic       w_boundary;
    logic       w_accept;
    bcd_t       w_digit;
    logic [6:0] w_glyph;
    logic       w_blink_blank;
    logic       w_lz_blank;

    assign w_boundary = (r_sel_q == 2'd3) && (SEL == 2'd0);
    assign w_accept   = DATA_VALID && (r_pend_state == PendEmpty);
    assign DATA_READY = (r_pend_state == PendEmpty);

    // Accept only when empty, commit only when full: the two never coincide, so a
    // same-cycle offer at a boundary with an empty buffer waits for the next frame.
    always_comb begin
        w_pend_state_d = r_pend_state;
        w_active_d     = r_active;
        unique case (r_pend_state)
            PendEmpty: if (w_accept) w_pend_state_d = PendFull;
            PendFull: begin
                if (w_boundary) begin
                    w_pend_state_d = PendEmpty;
                    w_active_d     = r_pending;
                end
            end
            default: w_pend_state_d = PendEmpty;
        endcase
    end

    // Decode from the post-commit value so the new frame's digit 0 appears right
    // after the boundary cycle.
    assign w_digit       = w_active_d[{SEL, 2'b00} +: 4];
    assign w_blink_blank = BLINK_MASK[SEL] && !r_blink_on;

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_lz_blank = 1'b0;
        case (SEL)
            2'd3:    w_lz_blank = (w_active_d[15:12] == 4'h0);
            2'd2:    w_lz_blank = (w_active_d[15:8] == 8'h00);
            2'd1:    w_lz_blank = (w_active_d[15:4] == 12'h000);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    seg7_decoder u_seg7_decoder (
        .i_bcd (w_digit),
        .o_seg (w_glyph)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pend_state <= PendEmpty;
            r_pending    <= 16'h0000;
            r_active     <= 16'h0000;
            r_sel_q      <= 2'd0;
        end else begin
            r_pend_state <= w_pend_state_d;
            r_active     <= w_active_d;
            r_sel_q      <= SEL;
            if (w_accept) r_pending <= DATA_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == CNT_MAX) begin
            r_blink_cnt <= '0;
            r_blink_on  <= !r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~({{(NUM_DIGITS - 1){1'b0}}, 1'b1} << SEL);
            r_seg <= (w_blink_blank || w_lz_blank) ? SEG_BLANK : w_glyph;
            // Leading-zero blanking deliberately leaves the decimal point alone.
            r_dp  <= !((SEL == 2'd2) && COLON && !w_blink_blank);
        end
    end

    assign AN  = r_an;
    assign SEG = r_seg;
    assign DP  = r_dp;

endmodule

// File: tb/tb_display_digit_driver.sv
// Testbench for display_digit_driver: directed scenarios followed by random scan
// traffic. Each driven cycle pushes the expected next-cycle outputs into a queue;
// a separate monitor pops and compares one entry after every rising edge.
module tb_display_digit_driver;

    localparam int unsigned BlinkDiv = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [1:0]  SEL = 2'd0;
    logic [15:0] DATA_IN = 16'h0000;
    logic        DATA_VALID = 1'b0;
    logic        DATA_READY;
    logic [3:0]  BLINK_MASK = 4'h0;
    logic        COLON = 1'b0;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    display_digit_driver #(
        .BLINK_DIV (BlinkDiv)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SEL        (SEL),
        .DATA_IN    (DATA_IN),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .BLINK_MASK (BLINK_MASK),
        .COLON      (COLON),
        .AN         (AN),
        .SEG        (SEG),
        .DP         (DP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: the value shown, the pending offers, last SEL, cycles since reset.
    logic [15:0] m_active;
    logic [15:0] m_pend[$];
    logic [1:0]  m_sel_q;
    int          m_ticks;
    logic [6:0]  glyph_tab[16];

    initial begin
        glyph_tab[0] = 7'b1000000; glyph_tab[1] = 7'b1111001;
        glyph_tab[2] = 7'b0100100; glyph_tab[3] = 7'b0110000;
        glyph_tab[4] = 7'b0011001; glyph_tab[5] = 7'b0010010;
        glyph_tab[6] = 7'b0000010; glyph_tab[7] = 7'b1111000;
        glyph_tab[8] = 7'b0000000; glyph_tab[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) glyph_tab[i] = 7'b0111111;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 16'h0000;
        m_pend.delete();
        m_sel_q  = 2'd0;
        m_ticks  = 0;
    endtask

    // Drive one cycle's inputs (caller is at a falling edge) and predict the outputs
    // that follow the next rising edge.
    task automatic drive_step(input logic [1:0] sel, input logic valid, input logic [15:0] data,
                              input logic [3:0] mask, input logic colon);
        exp_t        e;
        logic [15:0] sh;
        logic        boundary, was_empty, blink_on, blanked, lz;
        SEL        = sel;
        DATA_VALID = valid;
        DATA_IN    = data;
        BLINK_MASK = mask;
        COLON      = colon;
        boundary   = (m_sel_q == 2'd3) && (sel == 2'd0);
        was_empty  = (m_pend.size() == 0);
        blink_on   = ((m_ticks / BlinkDiv) % 2) == 0;
        if (boundary && !was_empty) m_active = m_pend.pop_front();
        if (valid && was_empty) m_pend.push_back(data);
        sh      = m_active >> (4 * sel);
        blanked = mask[sel] && !blink_on;
`ifdef LEADING_ZERO_BLANK_EN
        lz = (sel != 2'd0) && (sh == 16'h0000);
`else
        lz = 1'b0;
`endif
        e.an    = ~(4'b0001 << sel);
        e.seg   = (blanked || lz) ? 7'h7F : glyph_tab[sh[3:0]];
        e.dp    = !((sel == 2'd2) && colon && !blanked);
        e.ready = (m_pend.size() == 0);
        exp_q.push_back(e);
        m_sel_q = sel;
        m_ticks++;
    endtask

    task automatic cycle(input logic [1:0] sel, input logic valid, input logic [15:0] data,
                         input logic [3:0] mask, input logic colon);
        @(negedge CLK);
        drive_step(sel, valid, data, mask, colon);
    endtask

    task automatic frame(input logic [3:0] mask, input logic colon);
        for (int s = 0; s < 4; s++) cycle(2'(s), 1'b0, 16'h0000, mask, colon);
    endtask

    task automatic load_and_show(input logic [15:0] value, input logic colon);
        cycle(2'd0, 1'b0, 16'h0000, 4'h0, colon);
        cycle(2'd1, 1'b1, value, 4'h0, colon);
        cycle(2'd2, 1'b0, 16'h0000, 4'h0, colon);
        cycle(2'd3, 1'b0, 16'h0000, 4'h0, colon);
        frame(4'h0, colon);
        frame(4'h0, colon);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N      = 1'b0;
        DATA_VALID = 1'b0;
        SEL        = 2'd0;
        model_reset();
        repeat (10) @(negedge CLK);
        check("reset_an", 16'(AN), 16'hF);
        check("reset_seg", 16'(SEG), 16'h7F);
        check("reset_dp", 16'(DP), 16'h1);
        check("reset_ready", 16'(DATA_READY), 16'h1);
        RST_N = 1'b1;
        drive_step(2'd0, 1'b0, 16'h0000, 4'h0, 1'b0);
    endtask

    // Monitor: one expected entry per rising edge outside reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("an", 16'(AN), 16'(e.an));
                check("seg", 16'(SEG), 16'(e.seg));
                check("dp", 16'(DP), 16'(e.dp));
                check("ready", 16'(DATA_READY), 16'(e.ready));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sel;
        logic [15:0] data;
        do_reset();
        frame(4'h0, 1'b0);

        // Load 1234 mid-frame; 5678 offered while full is dropped.
        cycle(2'd0, 1'b0, 16'h0000, 4'h0, 1'b1);
        cycle(2'd1, 1'b1, 16'h1234, 4'h0, 1'b1);
        cycle(2'd2, 1'b1, 16'h5678, 4'h0, 1'b1);
        cycle(2'd3, 1'b1, 16'h5678, 4'h0, 1'b1);
        frame(4'h0, 1'b1);
        frame(4'h0, 1'b1);

        // Offer exactly on the boundary with the buffer empty.
        cycle(2'd0, 1'b1, 16'h5678, 4'h0, 1'b1);
        cycle(2'd1, 1'b0, 16'h0000, 4'h0, 1'b1);
        cycle(2'd2, 1'b0, 16'h0000, 4'h0, 1'b1);
        cycle(2'd3, 1'b0, 16'h0000, 4'h0, 1'b1);
        frame(4'h0, 1'b1);

        load_and_show(16'h00A9, 1'b0);

        // Blink: hold digit 0, then scan with digit 0 and digit 2 masked.
        for (int i = 0; i < 16; i++) cycle(2'd0, 1'b0, 16'h0000, 4'b0001, 1'b1);
        for (int i = 0; i < 4; i++) frame(4'b0101, 1'b1);

        load_and_show(16'h0050, 1'b1);
        load_and_show(16'h0000, 1'b1);

        // Random scan traffic, mostly in order, with one reset part-way.
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            if ($urandom_range(0, 9) < 7) sel = m_sel_q + 2'd1;
            else sel = 2'($urandom_range(0, 3));
            data = 16'($urandom);
            if ($urandom_range(0, 1) == 0) data = data & 16'h0F0F;
            cycle(sel, ($urandom_range(0, 3) == 0), data, 4'($urandom), 1'($urandom));
        end

        @(negedge CLK);
        DATA_VALID = 1'b0;
        @(negedge CLK);
        check("drain", 16'(exp_q.size()), 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
